cs_frame_sequencer: RTL and testbench

Frame-level controller for the compressed_sensing core. It accepts one frame of N input samples over a valid/ready stream and stores them in an internal frame buffer. It then releases the core from reset and serves samples combinationally by the core's value_counter. When the core raises end_flag, it captures output_symbols and hands the result downstream over a valid/ready handshake. It replaces the hand-written sample table and reset toggling with a reusable sequencer that sits between the sample source and the core.

---
 rtl/cs_frame_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_cs_frame_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/cs_frame_sequencer.sv
// ---------------------------------------------------------------------------
// cs_frame_sequencer
//   Frame-level controller for the compressed_sensing core. It loads one frame
//   of N_SAMPLES samples into a local buffer. It then runs the core out of
//   reset, serving samples by the core's value_counter. It captures the
//   core's output symbols on end_flag and hands them downstream.
//
//   FSM: IDLE -> LOAD -> RUN -> RESULT -> IDLE
//
// Ports
//   sys_clk, sys_reset        clock, async active-low reset
//   start / busy              frame request (IDLE only) / not-IDLE status
//   s_valid/s_ready/s_data    sample input stream (ready only in LOAD)
//   core_reset_n              core reset, released only while in RUN
//   core_values               buf[core_value_counter], 0 past the frame
//   core_value_counter        core sample index
//   core_output_symbols       core result
//   core_end_flag             core completion, sampled only in RUN
//   m_valid/m_ready/m_data    result output handshake
//   done                      one-cycle pulse the cycle after a result handshake
//   err                       sticky RUN timeout flag
//   frame_count               completed frames, wraps at 16 bits
//
// Build option
//   CS_TIMEOUT_EN  when defined, RUN aborts to IDLE and sets err after
//                  TIMEOUT_CYCLES cycles without core_end_flag. Otherwise RUN
//                  waits indefinitely and err is tied low.
// ---------------------------------------------------------------------------
module cs_frame_sequencer #(
  parameter int N_SAMPLES      = 96,
  parameter int SAMPLE_W       = 4,
  parameter int SYM_W          = 4,
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                sys_clk,
  input  logic                sys_reset,
  input  logic                start,
  output logic                busy,
  input  logic                s_valid,
  input  logic [SAMPLE_W-1:0] s_data,
  output logic                s_ready,
  output logic                core_reset_n,
  output logic [SAMPLE_W-1:0] core_values,
  input  logic [CNT_W-1:0]    core_value_counter,
  input  logic [SYM_W-1:0]    core_output_symbols,
  input  logic                core_end_flag,
  output logic                m_valid,
  output logic [SYM_W-1:0]    m_data,
  input  logic                m_ready,
  output logic                done,
  output logic                err,
  output logic [15:0]         frame_count
);

  localparam int PTR_W = $clog2(N_SAMPLES);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_RESULT} state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [SAMPLE_W-1:0] mem_q [N_SAMPLES];
  logic                m_valid_q, m_valid_d;
  logic [SYM_W-1:0]    m_data_q, m_data_d;
  logic                done_q, done_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic                wr_en, last_wr, timeout;

  assign wr_en   = (state_q == S_LOAD) && s_valid;
  assign last_wr = wr_en && (wr_ptr_q == PTR_W'(N_SAMPLES - 1));

`ifdef CS_TIMEOUT_EN
  localparam int RC_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [RC_W-1:0] run_cnt_q;
  logic            err_q, err_d;

  // Counter is held at 0 outside RUN, so it restarts on every RUN entry.
  // The compare fires in the TIMEOUT_CYCLES-th RUN cycle. end_flag has
  // priority over a timeout in the same cycle.
  assign timeout = (state_q == S_RUN) && !core_end_flag &&
                   (run_cnt_q == RC_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge sys_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      run_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      run_cnt_q <= (state_q == S_RUN) ? run_cnt_q + 1'b1 : '0;
      err_q     <= err_d;
    end
  end

  always_comb begin
    err_d = err_q;
    if (state_q == S_IDLE && start) err_d = 1'b0;
    if (timeout)                    err_d = 1'b1;
  end

  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  // Frame buffer: cleared on reset, persists across frames.
  always_ff @(posedge sys_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      for (int i = 0; i < N_SAMPLES; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

  // The core's counter may run past the frame, so out-of-range reads return 0.
  always_comb begin
    core_values = '0;
    if (core_value_counter < CNT_W'(N_SAMPLES))
      core_values = mem_q[core_value_counter[PTR_W-1:0]];
  end

  always_ff @(posedge sys_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      done_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      done_q      <= done_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    done_d      = 1'b0;
    frame_cnt_d = frame_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_LOAD;
          wr_ptr_d = '0;
        end
      end
      S_LOAD: begin
        if (wr_en) begin
          wr_ptr_d = last_wr ? '0 : wr_ptr_q + 1'b1;
          if (last_wr) state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (core_end_flag) begin
          m_data_d  = core_output_symbols;
          m_valid_d = 1'b1;
          state_d   = S_RESULT;
        end else if (timeout) begin
          state_d = S_IDLE;
        end
      end
      S_RESULT: begin
        if (m_valid_q && m_ready) begin
          m_valid_d   = 1'b0;
          done_d      = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy         = (state_q != S_IDLE);
  assign s_ready      = (state_q == S_LOAD);
  assign core_reset_n = (state_q == S_RUN);
  assign m_valid      = m_valid_q;
  assign m_data       = m_data_q;
  assign done         = done_q;
  assign frame_count  = frame_cnt_q;

endmodule

// File: tb/tb_cs_frame_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for cs_frame_sequencer. It drives random frames and a stub core,
// then checks the outputs against a simple buffer/counter reference.
// With CS_TIMEOUT_EN defined, the DUT is built with TIMEOUT_CYCLES=16 and the
// timeout path is exercised.
// ---------------------------------------------------------------------------
module tb_cs_frame_sequencer;
  localparam int N  = 96;
  localparam int SW = 4;
  localparam int YW = 4;
  localparam int CW = 8;
`ifdef CS_TIMEOUT_EN
  localparam int TO    = 16;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO    = 1024;
  localparam bit TO_EN = 1'b0;
`endif

  logic          sys_clk, sys_reset, start, busy, s_valid, s_ready, core_reset_n;
  logic [SW-1:0] s_data, core_values;
  logic [CW-1:0] core_value_counter;
  logic [YW-1:0] core_output_symbols, m_data;
  logic          core_end_flag, m_valid, m_ready, done, err;
  logic [15:0]   frame_count;

  cs_frame_sequencer #(
    .N_SAMPLES(N), .SAMPLE_W(SW), .SYM_W(YW), .CNT_W(CW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .sys_clk(sys_clk), .sys_reset(sys_reset), .start(start), .busy(busy),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .core_reset_n(core_reset_n), .core_values(core_values),
    .core_value_counter(core_value_counter),
    .core_output_symbols(core_output_symbols), .core_end_flag(core_end_flag),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .done(done),
    .err(err), .frame_count(frame_count)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference: expected buffer contents and completed-frame count.
  logic [SW-1:0] exp_mem [N];
  int            exp_fc;
  int            n_vec, n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  // Start a frame and stream N samples.
  // mode 0: s_valid always high; 1: every other cycle; 2: random.
  task automatic load_frame(input int mode, input bit pat, input bit noise);
    logic [SW-1:0] smp [N];
    int ones [10] = '{8, 13, 23, 26, 29, 40, 57, 58, 59, 77};
    int idx, it, rdy;
    bit sv;
    for (int i = 0; i < N; i++) smp[i] = pat ? '0 : SW'($urandom);
    if (pat) foreach (ones[i]) smp[ones[i]] = SW'(1);
    chk("idle_busy", {31'd0, busy}, 0);
    start = 1'b1; tick; start = 1'b0;
    chk("start_to_ready", {31'd0, s_ready}, 1);
    idx = 0; it = 0; rdy = 0;
    while (idx < N && it < 4000) begin
      sv = (mode == 0) ? 1'b1 : (mode == 1) ? (it % 2 == 0) : ($urandom_range(0, 99) < 60);
      s_valid = sv;
      s_data  = sv ? smp[idx] : SW'($urandom);
      if (noise && $urandom_range(0, 7) == 0) start = 1'b1;
      if (s_ready) rdy++;
      if (sv && s_ready) begin
        exp_mem[idx] = smp[idx];
        idx++;
      end
      it++;
      tick;
      start = 1'b0;
    end
    s_valid = 1'b1;  // keep offering data: no write may land outside LOAD
    chk("ready_cycles", rdy, it);
    chk("ready_low_in_run", {31'd0, s_ready}, 0);
    chk("core_rstn_rise", {31'd0, core_reset_n}, 1);
  endtask

  // Sweep the core counter through RUN, then finish with end_flag and result handshake.
  task automatic finish_frame(input bit pat, input bit noise);
    int run_len, c, hold, mv;
    logic [YW-1:0] sym;
    run_len = TO_EN ? 12 : N + 3;
    for (int k = 0; k < run_len; k++) begin
      if (TO_EN) c = (k == 0) ? N : (k == 1) ? 255 : $urandom_range(0, N - 1);
      else       c = (k == N + 2) ? 255 : k;
      core_value_counter = CW'(c);
      #1;
      chk("run_rstn", {31'd0, core_reset_n}, 1);
      chk("core_values", {28'd0, core_values}, (c < N) ? {28'd0, exp_mem[c]} : 32'd0);
      if (noise && k == 3) start = 1'b1;
      tick;
      start = 1'b0;
    end
    s_valid = 1'b0;
    sym = pat ? 4'hA : YW'($urandom);
    core_end_flag = 1'b1; core_output_symbols = sym;
    tick;
    core_end_flag = 1'b0; core_output_symbols = ~sym;
    chk("end_to_mvalid", {31'd0, m_valid}, 1);
    chk("rstn_drop", {31'd0, core_reset_n}, 0);
    hold = pat ? 5 : $urandom_range(0, 4);
    mv = 0;
    for (int h = 0; h < hold; h++) begin
      m_ready = 1'b0;
      if (m_valid) mv++;
      chk("m_data_hold", {28'd0, m_data}, {28'd0, sym});
      if (noise) start = 1'b1;
      tick;
      start = 1'b0;
    end
    m_ready = 1'b1;
    if (noise) start = 1'b1;  // start coincident with the handshake is ignored
    if (m_valid) mv++;
    chk("m_data_hs", {28'd0, m_data}, {28'd0, sym});
    tick;
    m_ready = 1'b0; start = 1'b0;
    exp_fc++;
    chk("m_valid_cycles", mv, hold + 1);
    chk("m_valid_drop", {31'd0, m_valid}, 0);
    chk("done_pulse", {31'd0, done}, 1);
    chk("frame_count", {16'd0, frame_count}, exp_fc);
    chk("back_idle", {31'd0, busy}, 0);
    tick;
    chk("done_single", {31'd0, done}, 0);
    chk("still_idle", {31'd0, busy}, 0);
    chk("err_clear", {31'd0, err}, 0);
  endtask

  initial begin
    n_vec = 0; n_err = 0; exp_fc = 0;
    foreach (exp_mem[i]) exp_mem[i] = '0;
    sys_reset = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0;
    core_value_counter = '0; core_output_symbols = '0; core_end_flag = 1'b0; m_ready = 1'b0;
    repeat (3) tick;
    sys_reset = 1'b1;
    tick;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_s_ready", {31'd0, s_ready}, 0);
    chk("rst_core_rstn", {31'd0, core_reset_n}, 0);
    chk("rst_m_valid", {31'd0, m_valid}, 0);
    chk("rst_m_data", {28'd0, m_data}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_fc", {16'd0, frame_count}, 0);
    chk("rst_values", {28'd0, core_values}, 0);

    load_frame(0, 1'b1, 1'b0); finish_frame(1'b1, 1'b0);
    load_frame(1, 1'b0, 1'b0); finish_frame(1'b0, 1'b0);
    for (int f = 0; f < 3; f++) begin
      load_frame(2, 1'b0, 1'b1); finish_frame(1'b0, 1'b1);
    end

    // end_flag outside RUN must be ignored.
    core_end_flag = 1'b1; core_output_symbols = 4'hF;
    tick;
    core_end_flag = 1'b0;
    chk("idle_endflag_mvalid", {31'd0, m_valid}, 0);
    chk("idle_endflag_busy", {31'd0, busy}, 0);

    // Asynchronous reset in the middle of RUN.
    load_frame(0, 1'b0, 1'b0);
    s_valid = 1'b0;
    repeat (3) tick;
    #2 sys_reset = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_core_rstn", {31'd0, core_reset_n}, 0);
    chk("midrst_s_ready", {31'd0, s_ready}, 0);
    chk("midrst_fc", {16'd0, frame_count}, 0);
    chk("midrst_m_valid", {31'd0, m_valid}, 0);
    exp_fc = 0;
    foreach (exp_mem[i]) exp_mem[i] = '0;
    tick;
    sys_reset = 1'b1;
    tick;
    for (int c = 0; c < N; c += 7) begin
      core_value_counter = CW'(c);
      tick;
      chk("buf_cleared", {28'd0, core_values}, 0);
    end
    load_frame(2, 1'b0, 1'b0); finish_frame(1'b0, 1'b0);

    if (TO_EN) begin
      load_frame(0, 1'b0, 1'b0);
      s_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
        chk("to_run", {31'd0, core_reset_n}, 1);
        tick;
      end
      chk("to_err", {31'd0, err}, 1);
      chk("to_idle", {31'd0, busy}, 0);
      chk("to_no_mvalid", {31'd0, m_valid}, 0);
      chk("to_fc", {16'd0, frame_count}, exp_fc);
      tick;
      chk("to_no_done", {31'd0, done}, 0);
      chk("to_err_sticky", {31'd0, err}, 1);
      start = 1'b1; tick; start = 1'b0;
      chk("to_err_cleared", {31'd0, err}, 0);
      chk("to_reload", {31'd0, s_ready}, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
